// File: rtl/consec_run_detector.sv
// Consecutive-run detector for one qualified serial lane: counts runs of RUN_TGT bits,
// pulses match when a run reaches the programmed length, and keeps a saturating hit count.
module consec_run_detector #(
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int RUN_TGT = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [LEN_W-1:0] run_len,
    input  logic             overlap,
    input  logic             clr,
    output logic             match,
    output logic [LEN_W-1:0] run_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_t;

    localparam logic             TGT_BIT = (RUN_TGT != 0);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
        return (v == LEN_MAX) ? v : v + LEN_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // A programmed length of zero behaves as a single-bit run.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] v);
        return (v == '0) ? LEN_W'(1) : v;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_run_cnt;
    logic [LEN_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] w_hit_nxt;
    logic             r_match;
    logic             w_match_nxt;
    logic [LEN_W-1:0] w_n;
    logic [LEN_W-1:0] w_len;
    logic             w_is_tgt;

    assign w_is_tgt = (in_bit == TGT_BIT);
    assign w_n      = sat_inc_len(r_run_cnt);
    assign w_len    = eff_len(run_len);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_run_cnt <= '0;
            r_hit_cnt <= '0;
            r_match   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_nxt;
            r_hit_cnt <= w_hit_nxt;
            r_match   <= w_match_nxt;
        end
    end

    // clr outranks everything else; idle cycles hold state but never stretch match.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run_cnt;
        w_hit_nxt   = r_hit_cnt;
        w_match_nxt = 1'b0;
        if (clr) begin
            w_state_nxt = IDLE;
            w_run_nxt   = '0;
            w_hit_nxt   = '0;
        end else if (in_valid) begin
            if (!w_is_tgt) begin
                w_state_nxt = IDLE;
                w_run_nxt   = '0;
            end else if (w_n >= w_len) begin
                w_state_nxt = HIT;
                w_match_nxt = 1'b1;
                w_hit_nxt   = sat_inc_cnt(r_hit_cnt);
                w_run_nxt   = overlap ? w_n : '0;
            end else begin
                w_state_nxt = RUN;
                w_run_nxt   = w_n;
            end
        end
    end

    assign match   = r_match;
    assign run_cnt = r_run_cnt;
    assign hit_cnt = r_hit_cnt;
    assign state   = r_state;

endmodule

// File: tb/tb_consec_run_detector.sv
// Directed bench for consec_run_detector: default instance plus a narrow hit counter instance.
module tb_consec_run_detector;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic [3:0] run_len;
    logic       overlap;
    logic       clr;

    logic       a_match;
    logic [3:0] a_run_cnt;
    logic [7:0] a_hit_cnt;
    logic [1:0] a_state;

    logic       b_match;
    logic [3:0] b_run_cnt;
    logic [1:0] b_hit_cnt;
    logic [1:0] b_state;

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    always #5 clock = ~clock;

    consec_run_detector #(.LEN_W(4), .CNT_W(8), .RUN_TGT(0)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .run_len(run_len), .overlap(overlap), .clr(clr),
        .match(a_match), .run_cnt(a_run_cnt), .hit_cnt(a_hit_cnt), .state(a_state)
    );

    consec_run_detector #(.LEN_W(4), .CNT_W(2), .RUN_TGT(0)) u_dut_narrow (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .run_len(run_len), .overlap(overlap), .clr(clr),
        .match(b_match), .run_cnt(b_run_cnt), .hit_cnt(b_hit_cnt), .state(b_state)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs, then check the registered outputs of the default instance.
    task automatic step(input string tag, input logic v, input logic b,
                        input int e_m, input int e_run, input int e_hit, input int e_st);
        in_valid = v;
        in_bit   = b;
        @(posedge clock);
        #1;
        chk({tag, ".match"},   int'(a_match),   e_m);
        chk({tag, ".run_cnt"}, int'(a_run_cnt), e_run);
        chk({tag, ".hit_cnt"}, int'(a_hit_cnt), e_hit);
        chk({tag, ".state"},   int'(a_state),   e_st);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step("clr", 1'b1, 1'b1, 0, 0, 0, 0);
        clr = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b1;
        in_bit   = 1'b0;
        run_len  = 4'd2;
        overlap  = 1'b0;
        clr      = 1'b0;

        // Reset held two cycles with target bits present.
        step("rst0", 1'b1, 1'b0, 0, 0, 0, 0);
        step("rst1", 1'b1, 1'b0, 0, 0, 0, 0);
        chk("rst.narrow_hit", int'(b_hit_cnt), 0);
        reset = 1'b1;
        step("rel_first", 1'b1, 1'b0, 0, 1, 0, 1);
        step("rel_break", 1'b1, 1'b1, 0, 0, 0, 0);

        // L=2, non-overlapping: stream 1,0,0,0,0,1
        step("nov1", 1'b1, 1'b1, 0, 0, 0, 0);
        step("nov2", 1'b1, 1'b0, 0, 1, 0, 1);
        step("nov3", 1'b1, 1'b0, 1, 0, 1, 2);
        step("nov4", 1'b1, 1'b0, 0, 1, 1, 1);
        step("nov5", 1'b1, 1'b0, 1, 0, 2, 2);
        step("nov6", 1'b1, 1'b1, 0, 0, 2, 0);

        // Same stream, overlapping.
        do_clr();
        overlap = 1'b1;
        step("ov1", 1'b1, 1'b1, 0, 0, 0, 0);
        step("ov2", 1'b1, 1'b0, 0, 1, 0, 1);
        step("ov3", 1'b1, 1'b0, 1, 2, 1, 2);
        step("ov4", 1'b1, 1'b0, 1, 3, 2, 2);
        step("ov5", 1'b1, 1'b0, 1, 4, 3, 2);
        step("ov6", 1'b1, 1'b1, 0, 0, 3, 0);

        // L=3 with an idle gap mid-run; then HIT held through an idle cycle.
        do_clr();
        overlap = 1'b0;
        run_len = 4'd3;
        step("gap1", 1'b1, 1'b0, 0, 1, 0, 1);
        step("gap2", 1'b1, 1'b0, 0, 2, 0, 1);
        for (int i = 0; i < 3; i++) step("gap_idle", 1'b0, 1'b1, 0, 2, 0, 1);
        step("gap_hit", 1'b1, 1'b0, 1, 0, 1, 2);
        step("hit_idle", 1'b0, 1'b0, 0, 0, 1, 2);
        step("hit_exit", 1'b1, 1'b1, 0, 0, 1, 0);

        // L=1 overlapping, six target bits: narrow counter saturates at 3.
        do_clr();
        overlap = 1'b1;
        run_len = 4'd1;
        for (int i = 1; i <= 6; i++) begin
            step("sat_hit", 1'b1, 1'b0, 1, i, i, 2);
            chk("sat_hit.narrow_hit", int'(b_hit_cnt), (i > 3) ? 3 : i);
            chk("sat_hit.narrow_match", int'(b_match), 1);
        end

        // clr on the completing bit suppresses the match.
        do_clr();
        overlap = 1'b0;
        run_len = 4'd3;
        step("clrw1", 1'b1, 1'b0, 0, 1, 0, 1);
        step("clrw2", 1'b1, 1'b0, 0, 2, 0, 1);
        clr = 1'b1;
        step("clrw3", 1'b1, 1'b0, 0, 0, 0, 0);
        clr = 1'b0;

        // Reset mid-run discards the partial run.
        run_len = 4'd5;
        step("mr1", 1'b1, 1'b0, 0, 1, 0, 1);
        step("mr2", 1'b1, 1'b0, 0, 2, 0, 1);
        step("mr3", 1'b1, 1'b0, 0, 3, 0, 1);
        reset = 1'b0;
        step("mr_rst", 1'b1, 1'b0, 0, 0, 0, 0);
        reset = 1'b1;

        // run_len lowered mid-run below current count: next target bit matches.
        overlap = 1'b1;
        step("rl1", 1'b1, 1'b0, 0, 1, 0, 1);
        step("rl2", 1'b1, 1'b0, 0, 2, 0, 1);
        step("rl3", 1'b1, 1'b0, 0, 3, 0, 1);
        run_len = 4'd2;
        step("rl_chg", 1'b1, 1'b0, 1, 4, 1, 2);

        // run_len=0 acts as 1.
        do_clr();
        run_len = 4'd0;
        step("len0", 1'b1, 1'b0, 1, 1, 1, 2);

        // run_cnt saturation at 15 with L=15 overlapping.
        do_clr();
        run_len = 4'd15;
        for (int i = 1; i <= 14; i++) step("rsat_run", 1'b1, 1'b0, 0, i, 0, 1);
        step("rsat15", 1'b1, 1'b0, 1, 15, 1, 2);
        step("rsat16", 1'b1, 1'b0, 1, 15, 2, 2);
        step("rsat17", 1'b1, 1'b0, 1, 15, 3, 2);
        step("rsat_end", 1'b1, 1'b1, 0, 0, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/consec_run_detector.md
Name: consec_run_detector

Overview:
- Parametrised successor to the two-zero sequence detector.
- Watches a qualified serial bit stream for runs of RUN_TGT-valued bits of programmable length, with overlapping or non-overlapping counting.
- Reports a single-cycle match pulse, the live run length and a saturating match counter.
- Sits between the serial front end and the status/interrupt logic; one instance per serial lane.

Parameters:
- LEN_W, 4: width of run_len and run_cnt; maximum programmable run is 2^LEN_W-1.
- CNT_W, 8: width of hit_cnt.
- RUN_TGT, 0: bit value whose consecutive occurrences are counted (0 or 1).

Ports:
- clock, input, 1: system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-low reset.
- in_valid, input, 1: in_bit qualifier; cycles with in_valid=0 are ignored (state held).
- in_bit, input, 1: serial data bit.
- run_len, input, LEN_W: required run length; sampled every valid cycle; value 0 treated as 1.
- overlap, input, 1: 1 = overlapping matches, 0 = run restarts after each match.
- clr, input, 1: synchronous clear of run state and hit_cnt.
- match, output, 1: registered one-cycle pulse when a run completes.
- run_cnt, output, LEN_W: current consecutive-target count, saturating at all-ones.
- hit_cnt, output, CNT_W: number of matches since reset/clr, saturating at all-ones.
- state, output, 2: FSM state: 0 = IDLE, 1 = RUN, 2 = HIT.

Behaviour:
- Reset:
  - Sampled at the rising edge while reset=0.
  - All outputs go to 0: match=0, run_cnt=0, hit_cnt=0, state=IDLE.
  - Reset mid-run discards the partial run.
  - Reset has priority over clr and in_valid.
- clr=1 (reset high): run_cnt=0, hit_cnt=0, state=IDLE, match=0 next cycle. The input bit in that cycle is ignored. clr wins over a simultaneous match.
- in_valid=0: run_cnt, hit_cnt and state hold; match=0 next cycle.
- Effective length L = (run_len==0) ? 1 : run_len.
- Valid cycle, in_bit != RUN_TGT: run_cnt=0, state=IDLE, match=0.
- Valid cycle, in_bit == RUN_TGT: n = run_cnt+1, saturating at 2^LEN_W-1.
  - If n >= L: match=1, hit_cnt+1 (saturating, hold at all-ones), state=HIT.
    - overlap=1: run_cnt=n.
    - overlap=0: run_cnt=0.
  - Else: run_cnt=n, state=RUN, match=0.
- Latency: match, run_cnt, hit_cnt and state update on the clock edge that samples the completing bit. They are visible in the cycle after that bit is presented. No combinational input-to-output path.
- HIT lasts one valid cycle. It exits to RUN or HIT on the next target bit, or to IDLE on a non-target bit or clr.
- With in_valid=0, HIT holds but match drops after one cycle; the match pulse is never stretched.
- Back-to-back matches:
  - overlap=1: a match on every target bit once run_cnt >= L.
  - overlap=0: a match every L target bits.
- run_len changed mid-run: compared against the current run_cnt on the next valid target bit. If run_cnt is already >= the new L, that bit matches.
- overlap changed mid-run: takes effect on the next valid cycle only.
- Saturation: once run_cnt saturates with overlap=1, matching continues every target bit.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1, in_bit=RUN_TGT -> all outputs 0, state=IDLE. After release, first target bit gives run_cnt=1.
- RUN_TGT=0, run_len=2, overlap=0, stream 1,0,0,0,0,1 (all valid) -> match pulses after the 3rd and 5th bits, hit_cnt=2, run_cnt returns to 0 after the 1.
- Same stream, overlap=1 -> match after the 3rd, 4th and 5th bits; hit_cnt=3; run_cnt peaks at 4.
- run_len=3, stream 0,0,(in_valid=0 for 3 cycles),0 -> no match during the gap, run_cnt holds 2; match after the 3rd valid 0.
- CNT_W=2, overlap=1, run_len=1, six valid 0s -> hit_cnt 1,2,3,3,3,3; match high all six cycles.
- clr asserted on the cycle a completing 0 arrives -> no match, hit_cnt=0, run_cnt=0, state=IDLE. Reset=0 asserted mid-run with run_cnt=3 -> run_cnt=0 next cycle.
